uart_tx: RTL and testbench

- Serial UART transmitter. It takes parallel words over a valid/ready handshake and drives one LSB-first serial line.
- Frame order: start bit (0), DATA_WIDTH data bits, optional parity bit, then STOP_BITS stop bits (1).
- It is the transmit end of the team's UART path and uses the same frame format and shared state enum as the UART receiver.
- A one-word holding buffer allows back-to-back frames with no idle gap.

---
 rtl/shared_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 29 ++
 rtl/uart_baud_cnt.sv | 36 +++
 rtl/uart_tx.sv | 176 +++++++++++++++++
 tb/tb_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_pkg.sv
// Definitions shared by both ends of the UART path: word width, line levels and FSM states.
package shared_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_states_e;

endpackage

// File: rtl/uart_tx_if.sv
// Word-in / serial-out bundle between a producer and the UART transmitter.
interface uart_tx_if;

  logic [shared_pkg::DATA_WIDTH-1:0] tx_data;
  logic                              tx_valid;
  logic                              tx_ready;
  logic                              tx;
  logic                              tx_busy;
  logic                              tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: reloads on load, flags the last cycle of each serial bit.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_tick_c
);

  localparam int unsigned            CNT_W  = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]       RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick_c = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-word holding buffer feeding an LSB-first serial framer.
module uart_tx
  import shared_pkg::*;
#(
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int unsigned       BIT_W     = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned       STOP_W    = $clog2(STOP_BITS) + 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  uart_states_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic                  parity_q, parity_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0]     stop_cnt_q, stop_cnt_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  load_word;
  logic                  baud_load;
  logic                  bit_tick_c;
  logic                  accept;

  // Parity is taken from the whole word at load time, before any shifting.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] w);
    return (PARITY_EN == 2) ? ^w : ~^w;
  endfunction

  uart_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk        (clk),
    .rst        (rst),
    .load       (baud_load),
    .bit_tick_c (bit_tick_c)
  );

  assign accept = bus.tx_valid && ready_q;

  // Frame sequencing, buffer drain/fill and next-cycle line level.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    parity_d   = parity_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    done_d     = 1'b0;
    load_word  = 1'b0;
    baud_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          load_word = 1'b1;
        end
      end
      START: begin
        if (bit_tick_c) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          baud_load = 1'b1;
        end
      end
      DATA: begin
        if (bit_tick_c) begin
          shift_d   = shift_q >> 1;
          baud_load = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = '0;
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_tick_c) begin
          state_d    = STOP;
          stop_cnt_d = '0;
          baud_load  = 1'b1;
        end
      end
      STOP: begin
        if (bit_tick_c) begin
          if (stop_cnt_q == LAST_STOP) begin
            done_d = 1'b1;
            if (buf_full_q) begin
              load_word = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
            baud_load  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_word) begin
      state_d    = START;
      shift_d    = buf_q;
      parity_d   = parity_of(buf_q);
      buf_full_d = 1'b0;
      baud_load  = 1'b1;
    end

    // Accept only with the buffer empty, so this never collides with a drain.
    if (accept) begin
      buf_d      = bus.tx_data;
      buf_full_d = 1'b1;
    end

    tx_d = STOP_BIT;
    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = STOP_BIT;
    endcase

    busy_d  = (state_d != IDLE);
    ready_d = !buf_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      parity_q   <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      parity_q   <= parity_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations checked every cycle against a frame-level model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld [4];
  logic [7:0] dat [4];
  logic       tx_w [4];
  logic       rdy_w [4];
  logic       bsy_w [4];
  logic       dn_w [4];

  int total = 0;
  int bad   = 0;

  // Instance configurations: parity mode, stop bits, clocks per bit.
  int cfg_p [4] = '{0, 2, 1, 0};
  int cfg_s [4] = '{1, 1, 1, 2};
  int cfg_c [4] = '{1, 1, 1, 4};

  initial forever #5 clk = ~clk;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  uart_tx #(.PARITY_EN(0), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  uart_tx #(.PARITY_EN(2), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  uart_tx #(.PARITY_EN(1), .STOP_BITS(1), .CLKS_PER_BIT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  uart_tx #(.PARITY_EN(0), .STOP_BITS(2), .CLKS_PER_BIT(4)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  assign if0.tx_valid = vld[0];
  assign if0.tx_data  = dat[0];
  assign tx_w[0]      = if0.tx;
  assign rdy_w[0]     = if0.tx_ready;
  assign bsy_w[0]     = if0.tx_busy;
  assign dn_w[0]      = if0.tx_done;
  assign if1.tx_valid = vld[1];
  assign if1.tx_data  = dat[1];
  assign tx_w[1]      = if1.tx;
  assign rdy_w[1]     = if1.tx_ready;
  assign bsy_w[1]     = if1.tx_busy;
  assign dn_w[1]      = if1.tx_done;
  assign if2.tx_valid = vld[2];
  assign if2.tx_data  = dat[2];
  assign tx_w[2]      = if2.tx;
  assign rdy_w[2]     = if2.tx_ready;
  assign bsy_w[2]     = if2.tx_busy;
  assign dn_w[2]      = if2.tx_done;
  assign if3.tx_valid = vld[3];
  assign if3.tx_data  = dat[3];
  assign tx_w[3]      = if3.tx;
  assign rdy_w[3]     = if3.tx_ready;
  assign bsy_w[3]     = if3.tx_busy;
  assign dn_w[3]      = if3.tx_done;

  task automatic cmp(input string nm, input int inst, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", nm, inst, got, want);
    end
  endtask

  // Model: a per-instance list of line levels for the frame on the wire plus a one-word buffer.
  logic       frame_m [4][64];
  int         rem_m [4];
  int         idx_m [4];
  logic       bf_m [4];
  logic [7:0] buf_m [4];
  logic       dn_m [4];
  logic       started = 1'b0;

  task automatic build(input int i, input logic [7:0] w);
    logic bits [16];
    int   nb = 0;
    int   n  = 0;
    bits[nb++] = 1'b0;
    for (int b = 0; b < 8; b++) bits[nb++] = w[b];
    if (cfg_p[i] == 2) bits[nb++] = ($countones(w) % 2) == 1;
    if (cfg_p[i] == 1) bits[nb++] = ($countones(w) % 2) == 0;
    for (int s = 0; s < cfg_s[i]; s++) bits[nb++] = 1'b1;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < cfg_c[i]; c++) frame_m[i][n++] = bits[b];
    rem_m[i] = n;
    idx_m[i] = 0;
  endtask

  function automatic logic exp_tx(input int i);
    return (rem_m[i] > 0) ? frame_m[i][idx_m[i]] : 1'b1;
  endfunction

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        rem_m[i] = 0;
        idx_m[i] = 0;
        bf_m[i]  = 1'b0;
        dn_m[i]  = 1'b0;
      end else begin
        logic acc;
        acc      = vld[i] && !bf_m[i];
        dn_m[i]  = 1'b0;
        if (rem_m[i] > 0) begin
          rem_m[i]--;
          idx_m[i]++;
          if (rem_m[i] == 0) dn_m[i] = 1'b1;
        end
        if (rem_m[i] == 0 && bf_m[i]) begin
          build(i, buf_m[i]);
          bf_m[i] = 1'b0;
        end
        if (acc) begin
          bf_m[i]  = 1'b1;
          buf_m[i] = dat[i];
        end
      end
    end
    started = 1'b1;
  end

  // Every-cycle comparison of all instances against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < 4; i++) begin
        cmp("tx",    i, 64'(tx_w[i]),  64'(exp_tx(i)));
        cmp("ready", i, 64'(rdy_w[i]), 64'(!bf_m[i]));
        cmp("busy",  i, 64'(bsy_w[i]), 64'(rem_m[i] > 0));
        cmp("done",  i, 64'(dn_w[i]),  64'(dn_m[i]));
      end
    end
  end

  // Sample index k is the state after edge N+k, with the call made just after edge N.
  task automatic capture(input int i, input int n,
                         output logic [63:0] txs, output logic [63:0] dns,
                         output logic [63:0] bss, output logic [63:0] rds);
    txs = '0; dns = '0; bss = '0; rds = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      txs[k] = tx_w[i];
      dns[k] = dn_w[i];
      bss[k] = bsy_w[i];
      rds[k] = rdy_w[i];
    end
  endtask

  task automatic send(input int i, input logic [7:0] w);
    @(posedge clk); #1;
    vld[i] = 1'b1;
    dat[i] = w;
    @(posedge clk); #1;
    vld[i] = 1'b0;
  endtask

  function automatic int first_one(input logic [63:0] v);
    for (int k = 0; k < 64; k++) if (v[k]) return k;
    return -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] txs, dns, bss, rds;
    logic [7:0]  by;
    logic [7:0]  bp_exp [5];
    bp_exp = '{8'h10, 8'h12, 8'h1C, 8'h26, 8'h30};
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      cmp("rst_tx",    i, 64'(tx_w[i]),  64'd1);
      cmp("rst_ready", i, 64'(rdy_w[i]), 64'd1);
      cmp("rst_busy",  i, 64'(bsy_w[i]), 64'd0);
      cmp("rst_done",  i, 64'(dn_w[i]),  64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 0xA5, no parity, one stop bit.
    send(0, 8'hA5);
    capture(0, 14, txs, dns, bss, rds);
    cmp("a5_frame",   0, (txs >> 1) & 64'h3FF, 64'h34A);
    cmp("a5_done_at", 0, 64'(first_one(dns)), 64'd11);
    cmp("a5_busy",    0, (bss >> 1) & 64'h3FF, 64'h3FF);
    cmp("a5_busy_n",  0, 64'($countones(bss)), 64'd10);
    cmp("a5_ready0",  0, 64'(rds[0]), 64'd0);

    // Parity variants.
    send(1, 8'h07);
    capture(1, 14, txs, dns, bss, rds);
    cmp("even07_frame", 1, (txs >> 1) & 64'h7FF, 64'h60E);
    cmp("even07_par",   1, 64'(txs[10]), 64'd1);
    cmp("even07_done",  1, 64'(first_one(dns)), 64'd12);
    send(2, 8'h07);
    capture(2, 14, txs, dns, bss, rds);
    cmp("odd07_par",  2, 64'(txs[10]), 64'd0);
    cmp("odd07_done", 2, 64'(first_one(dns)), 64'd12);
    send(2, 8'h00);
    capture(2, 14, txs, dns, bss, rds);
    cmp("odd00_frame", 2, (txs >> 1) & 64'h7FF, 64'h600);
    cmp("odd00_par",   2, 64'(txs[10]), 64'd1);

    // Back-to-back 0x55 then 0x3C with tx_valid held.
    @(posedge clk); #1;
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    @(posedge clk); #1;
    dat[0] = 8'h3C;
    fork
      capture(0, 24, txs, dns, bss, rds);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
      end
    join
    cmp("b2b_frames", 0, (txs >> 1) & 64'h3FFFFF, 64'(22'b11_1001111000_1010101010));
    cmp("b2b_done",   0, (dns >> 1) & 64'h3FFFFF, 64'h100400);
    cmp("b2b_ready",  0, rds & 64'h7, 64'b010);

    // 0xFF at 4 clocks per bit, two stop bits.
    send(3, 8'hFF);
    capture(3, 48, txs, dns, bss, rds);
    cmp("ff_frame",   3, (txs >> 1) & 64'hFFF_FFFF_FFFF, 64'hFFF_FFFF_FFF0);
    cmp("ff_done_at", 3, 64'(first_one(dns)), 64'd45);
    cmp("ff_busy_n",  3, 64'($countones(bss)), 64'd44);

    // Reset during data bit 3 with a second word buffered.
    @(posedge clk); #1;
    vld[0] = 1'b1;
    dat[0] = 8'h96;
    @(posedge clk); #1;
    dat[0] = 8'h81;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("mid_bit3",  0, 64'(tx_w[0]),  64'd0);
    cmp("mid_ready", 0, 64'(rdy_w[0]), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    cmp("rst_mid_tx",    0, 64'(tx_w[0]),  64'd1);
    cmp("rst_mid_ready", 0, 64'(rdy_w[0]), 64'd1);
    cmp("rst_mid_busy",  0, 64'(bsy_w[0]), 64'd0);
    cmp("rst_mid_done",  0, 64'(dn_w[0]),  64'd0);
    @(posedge clk); #1;
    capture(0, 30, txs, dns, bss, rds);
    cmp("post_rst_tx",   0, txs & 64'h3FFF_FFFF, 64'h3FFF_FFFF);
    cmp("post_rst_done", 0, dns, 64'd0);
    cmp("post_rst_busy", 0, bss, 64'd0);

    // Backpressure: data changes every cycle while tx_valid stays high.
    @(posedge clk); #1;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          dat[0] = 8'(8'h10 + k);
          vld[0] = 1'b1;
          @(posedge clk); #1;
        end
        vld[0] = 1'b0;
      end
      begin
        @(posedge clk); #1;
        capture(0, 56, txs, dns, bss, rds);
      end
    join
    for (int j = 0; j < 5; j++) begin
      for (int b = 0; b < 8; b++) by[b] = txs[2 + 10*j + b];
      cmp("bp_word", j, 64'(by), 64'(bp_exp[j]));
    end
    cmp("bp_done_n", 0, 64'($countones(dns)), 64'd5);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
